// File: rtl/bsg_link_sdr_reset_sequencer.sv
// Reset sequencer for one SDR link channel: asserts all link resets, pulses the token reset,
// then releases downlink, uplink and downstream in turn, on power-up and on every retrain.

module bsg_link_sdr_reset_sequencer_chk #(
  parameter int assert_cycles_p = 8,
  parameter int token_cycles_p  = 8,
  parameter int settle_cycles_p = 16
) (
  input logic core_clk_i
);
  // Durations are loaded as (N-1), so anything below one cycle is meaningless
  always @(posedge core_clk_i) begin
    assert (assert_cycles_p >= 1) else $error("assert_cycles_p must be >= 1");
    assert (token_cycles_p >= 1)  else $error("token_cycles_p must be >= 1");
    assert (settle_cycles_p >= 1) else $error("settle_cycles_p must be >= 1");
  end
endmodule

module bsg_link_sdr_reset_sequencer #(
  parameter int assert_cycles_p = 8,
  parameter int token_cycles_p  = 8,
  parameter int settle_cycles_p = 16,
  parameter int auto_start_p    = 1
) (
  input  logic core_clk_i,
  input  logic core_reset_n_i,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  output logic core_uplink_reset_o,
  output logic core_downstream_reset_o,
  output logic async_downlink_reset_o,
  output logic async_token_reset_o
);
  localparam int max_at_lp = (assert_cycles_p > token_cycles_p) ? assert_cycles_p : token_cycles_p;
  localparam int max_lp    = (max_at_lp > settle_cycles_p) ? max_at_lp : settle_cycles_p;
  localparam int cnt_w_lp  = $clog2(max_lp + 1);

  localparam logic [cnt_w_lp-1:0] assert_load_lp = cnt_w_lp'(assert_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] token_load_lp  = cnt_w_lp'(token_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] settle_load_lp = cnt_w_lp'(settle_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] cnt_zero_lp    = cnt_w_lp'(0);
  localparam logic [cnt_w_lp-1:0] cnt_one_lp     = cnt_w_lp'(1);
  localparam logic                auto_start_lp  = (auto_start_p != 0);

  // Output vector order: {busy, done, uplink, downstream, downlink, token}
  localparam logic [5:0] idle_outs_lp = 6'b001110;

  typedef enum logic [2:0] {
    e_idle      = 3'd0,
    e_assert    = 3'd1,
    e_token     = 3'd2,
    e_token_clr = 3'd3,
    e_dn_rel    = 3'd4,
    e_up_rel    = 3'd5,
    e_done      = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                first_q;
  logic [5:0]          outs_q, outs_d;

  function automatic logic [5:0] outs_for(input state_e s);
    logic [5:0] o;
    case (s)
      e_idle:      o = 6'b001110;
      e_assert:    o = 6'b101110;
      e_token:     o = 6'b101111;
      e_token_clr: o = 6'b101110;
      e_dn_rel:    o = 6'b101100;
      e_up_rel:    o = 6'b100100;
      e_done:      o = 6'b010000;
      default:     o = 6'b001110;
    endcase
    return o;
  endfunction

  // Next state and counter; counter only decrements while nonzero, so it cannot wrap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      e_idle: begin
        if (start_i | (auto_start_lp & first_q)) begin
          state_d = e_assert;
          cnt_d   = assert_load_lp;
        end else begin
          state_d = e_idle;
        end
      end
      e_assert: begin
        if (cnt_q == cnt_zero_lp) begin
          state_d = e_token;
          cnt_d   = token_load_lp;
        end else begin
          cnt_d = cnt_q - cnt_one_lp;
        end
      end
      e_token: begin
        if (cnt_q == cnt_zero_lp) begin
          state_d = e_token_clr;
          cnt_d   = settle_load_lp;
        end else begin
          cnt_d = cnt_q - cnt_one_lp;
        end
      end
      e_token_clr: begin
        if (cnt_q == cnt_zero_lp) begin
          state_d = e_dn_rel;
          cnt_d   = settle_load_lp;
        end else begin
          cnt_d = cnt_q - cnt_one_lp;
        end
      end
      e_dn_rel: begin
        if (cnt_q == cnt_zero_lp) begin
          state_d = e_up_rel;
          cnt_d   = settle_load_lp;
        end else begin
          cnt_d = cnt_q - cnt_one_lp;
        end
      end
      e_up_rel: begin
        if (cnt_q == cnt_zero_lp) begin
          state_d = e_done;
          cnt_d   = cnt_zero_lp;
        end else begin
          cnt_d = cnt_q - cnt_one_lp;
        end
      end
      e_done: begin
        if (start_i) begin
          state_d = e_assert;
          cnt_d   = assert_load_lp;
        end else begin
          state_d = e_done;
        end
      end
      default: begin
        state_d = e_idle;
        cnt_d   = cnt_zero_lp;
      end
    endcase
  end

  assign outs_d = outs_for(state_d);

  // State, counter, one-shot auto-start flag and registered outputs
  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      state_q <= e_idle;
      cnt_q   <= cnt_zero_lp;
      first_q <= 1'b1;
      outs_q  <= idle_outs_lp;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= 1'b0;
      outs_q  <= outs_d;
    end
  end

  assign {busy_o, done_o, core_uplink_reset_o, core_downstream_reset_o,
          async_downlink_reset_o, async_token_reset_o} = outs_q;

  bsg_link_sdr_reset_sequencer_chk #(
    .assert_cycles_p(assert_cycles_p),
    .token_cycles_p (token_cycles_p),
    .settle_cycles_p(settle_cycles_p)
  ) chk (
    .core_clk_i(core_clk_i)
  );

endmodule
